gf2m_283_reducer: RTL



---
 rtl/gf2m_283_reducer.sv | 83 ++++++++
 1 files changed

// File: rtl/gf2m_283_reducer.sv
// Reduces a 566-bit carry-less product modulo x^283 + x^12 + x^7 + x^5 + 1.
// The fold is split across two registered steps, and results use a valid/ready handshake.
module gf2m_283_reducer #(
    parameter int M = 283
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*M-1:0]   c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M-1:0]     r_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FOLD1 = 2'd1,
        FOLD2 = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [2*M-1:0] acc;

    // First fold: x^283 == x^12 + x^7 + x^5 + 1. The result spills into at most
    // 12 bits above the field degree, so it is kept at M+12 bits.
    function automatic logic [M+11:0] fold_hi(input logic [2*M-1:0] a);
        logic [M+11:0] h;
        h = {12'b0, a[2*M-1:M]};
        return {12'b0, a[M-1:0]} ^ h ^ (h << 5) ^ (h << 7) ^ (h << 12);
    endfunction

    // Second fold: only 12 bits remain above degree M. Their image lands below bit 24, so nothing overflows.
    function automatic logic [M-1:0] fold_lo(input logic [M+11:0] a);
        logic [M-1:0] h;
        h = {{(M-12){1'b0}}, a[M+11:M]};
        return a[M-1:0] ^ h ^ (h << 5) ^ (h << 7) ^ (h << 12);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (in_valid) state_nxt = FOLD1;
            FOLD1: state_nxt = FOLD2;
            FOLD2: state_nxt = HOLD;
            HOLD:  if (out_ready) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            r_out <= '0;
        end else begin
            unique case (state)
                IDLE:  if (in_valid) acc <= c_in;
                FOLD1: acc <= {{(M-12){1'b0}}, fold_hi(acc)};
                FOLD2: begin
                    r_out <= fold_lo(acc[M+11:0]);
                    acc   <= '0;
                end
                HOLD:  ;
            endcase
        end
    end

endmodule
